mux_scan_capture: RTL and testbench
===================================

# mux_scan_capture

Sequential scanner that sits directly upstream of the 16:1 enabled multiplexer (data pins a–p, select q,r,s,t, enable u, output v). On each start request it runs a zero check with the mux disabled, then steps the select through all 16 channels and samples v after a programmable settle time. It assembles the 16 samples into one parallel word and delivers it downstream with a valid/ready handshake.

## Interface
- SETTLE, default 1: idle cycles between a select/enable change and its sample; legal range 0–15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  scan request; sampled only in IDLE.
- mux_v  in  1  mux output v.
- sel  out  4  mux select; sel[3]=q, sel[2]=r, sel[1]=s, sel[0]=t.
- mux_en  out  1  mux enable u.
- busy  out  1  high from start acceptance until the handshake completes.
- word  out  16  captured word; bit k = v sampled with sel=k, en=1.
- err  out  1  zero-check failure: v was 1 while en=0.
- valid  out  1  word/err available.
- ready  in  1  downstream accepts word.

## Operation
- States:
  - IDLE: sel=0, en=0, busy=0.
  - CHECK: en=0, sel=0.
  - SCAN: en=1, sel=ch.
  - DONE: en=0, sel=0, valid=1.
- Transitions:
  - IDLE→CHECK when start=1.
  - CHECK→SCAN after one step.
  - SCAN→DONE after the step with ch=15.
  - DONE→IDLE on valid&ready.
- Each step lasts SETTLE+1 cycles. The settle counter loads SETTLE when a step begins. mux_v is sampled on the edge where the counter reads 0; that same edge starts the next step.
- CHECK sample goes to an internal err_acc. SCAN sample k is written to acc[k].
- On the SCAN→DONE edge: word←acc with bit 15 = the final sample; err←err_acc. Both then hold until the next SCAN→DONE edge. They do not clear on handshake.
- start is ignored outside IDLE. A start held high continuously re-arms immediately after the return to IDLE.
- ready outside DONE has no effect. In DONE, valid holds until ready=1.
- All outputs are registered.

## Timing
- Reset values: sel=0, mux_en=0, busy=0, valid=0, word=0, err=0. State=IDLE; counters=0.
- Asserting rst_n low mid-scan aborts immediately: outputs take reset values asynchronously and the partial acc is discarded. After release, the block waits for a fresh start.
- Start accepted at edge E0: busy=1, CHECK outputs after E0.
  - CHECK sample at E0+(SETTLE+1).
  - Sample for channel k at E0+(k+2)(SETTLE+1).
  - valid rises after E0+17(SETTLE+1); 34 edges at SETTLE=1, 17 at SETTLE=0.
- With ready=1 already high in DONE, valid lasts exactly one cycle. valid and busy fall after the same edge; IDLE is entered there.
- sel/en change only on step boundaries. They are stable for the full SETTLE+1 cycles before each sample.

## Structure
- Package mux_scan_pkg holds:
  - state enum {IDLE, CHECK, SCAN, DONE};
  - constants NCH=16, SEL_W=4, CNT_W=4.
- Sub-module mux_scan_timer is the down-counter:
  - inputs: load, value;
  - output: expire, asserted when the count is 0.
- The top holds the FSM, channel counter, accumulator and output registers.

## Test plan
- Mux model, inputs a..p = 16'hA5C3, SETTLE=1, ready=1, one start pulse:
  - word=16'hA5C3, err=0;
  - valid rises exactly 34 cycles after start acceptance and lasts 1 cycle.
- SETTLE=0, all inputs 1:
  - word=16'hFFFF, valid at 17 cycles;
  - sel sequence 0,0(check),1..15 observed one value per cycle.
- Force mux_v=1 while en=0 (faulty model), inputs=0: word=16'h0000, err=1.
- Hold ready=0 for 10 cycles in DONE:
  - valid and word stay stable and busy stays 1;
  - start pulses during this time are ignored;
  - ready=1 → IDLE the next cycle.
- rst_n low at channel 7 of a scan: all outputs reset immediately; a new start then yields a correct full word with no carry-over bits.
- Start held high across two scans with differing inputs: two back-to-back captures, each with correct word.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16-channel mux scanner.
package mux_scan_pkg;

    localparam int unsigned NCH   = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StScan,
        StDone
    } state_e;

endpackage

// File: rtl/mux_scan_timer.sv
// Settle down-counter: reloads on load_i, otherwise counts down and parks at zero.
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_capture.sv
// Scans a 16:1 enabled mux: zero check with the mux disabled, then one sample per channel,
// delivered as a 16-bit word over a valid/ready handshake.
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mux_v_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             mux_en_o,
    output logic             busy_o,
    output logic [NCH-1:0]   word_o,
    output logic             err_o,
    output logic             valid_o,
    input  logic             ready_i
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [NCH-1:0]   acc_q, acc_d;
    logic             err_acc_q, err_acc_d;
    logic [NCH-1:0]   word_q, word_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             load;
    logic             expire;

    mux_scan_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .value_i  (CNT_W'(SETTLE)),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        acc_d     = acc_q;
        err_acc_d = err_acc_q;
        word_d    = word_q;
        err_d     = err_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCheck;
                    load    = 1'b1;
                end
            end
            StCheck: begin
                if (expire) begin
                    err_acc_d = mux_v_i;
                    ch_d      = '0;
                    state_d   = StScan;
                    load      = 1'b1;
                end
            end
            StScan: begin
                if (expire) begin
                    acc_d[ch_q] = mux_v_i;
                    load        = 1'b1;
                    if (ch_q == SEL_W'(NCH - 1)) begin
                        // Final sample goes straight into the word alongside the accumulated bits.
                        word_d  = acc_d;
                        err_d   = err_acc_q;
                        ch_d    = '0;
                        state_d = StDone;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins track the FSM with no lag.
    always_comb begin
        sel_d   = (state_d == StScan) ? ch_d : '0;
        en_d    = (state_d == StScan);
        busy_d  = (state_d != StIdle);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            acc_q     <= '0;
            err_acc_q <= 1'b0;
            word_q    <= '0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            err_acc_q <= err_acc_d;
            word_q    <= word_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign sel_o    = sel_q;
    assign mux_en_o = en_q;
    assign busy_o   = busy_q;
    assign word_o   = word_q;
    assign err_o    = err_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: two instances (SETTLE=1 and SETTLE=0) each driving a 16:1 mux model.
module tb_mux_scan_capture;

    logic clk;
    logic rst_n;

    logic        start1, ready1, fault1;
    logic [15:0] data1;
    logic [3:0]  sel1;
    logic        en1, busy1, err1, valid1, mux_v1;
    logic [15:0] word1;

    logic        start0, ready0, fault0;
    logic [15:0] data0;
    logic [3:0]  sel0;
    logic        en0, busy0, err0, valid0, mux_v0;
    logic [15:0] word0;

    int errors = 0;
    int checks = 0;

    // Mux model: v = enabled ? selected pin : fault level (0 for a healthy mux).
    assign mux_v1 = en1 ? data1[sel1] : fault1;
    assign mux_v0 = en0 ? data0[sel0] : fault0;

    mux_scan_capture #(.SETTLE(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start1),
        .mux_v_i  (mux_v1),
        .sel_o    (sel1),
        .mux_en_o (en1),
        .busy_o   (busy1),
        .word_o   (word1),
        .err_o    (err1),
        .valid_o  (valid1),
        .ready_i  (ready1)
    );

    mux_scan_capture #(.SETTLE(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start0),
        .mux_v_i  (mux_v0),
        .sel_o    (sel0),
        .mux_en_o (en0),
        .busy_o   (busy0),
        .word_o   (word0),
        .err_o    (err0),
        .valid_o  (valid0),
        .ready_i  (ready0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected latency from start acceptance to valid: 17 steps of SETTLE+1 cycles.
    function automatic int exp_latency(input int settle);
        return 17 * (settle + 1);
    endfunction

    task automatic wait_valid1(input int limit, output int m);
        m = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            m++;
        end while (!valid1 && m < limit);
    endtask

    // Pulse start for one edge; returns 1ns after the accepting edge.
    task automatic start_pulse1();
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic start_pulse0();
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel1, en1, busy1, valid1, word1, err1} !== 24'h0) begin
            errors++;
            $display("FAIL reset_dut1: got sel=%0d en=%b busy=%b valid=%b word=%h err=%b, need all 0",
                     sel1, en1, busy1, valid1, word1, err1);
        end
        checks++;
        if ({sel0, en0, busy0, valid0, word0, err0} !== 24'h0) begin
            errors++;
            $display("FAIL reset_dut0: got sel=%0d en=%b busy=%b valid=%b word=%h err=%b, need all 0",
                     sel0, en0, busy0, valid0, word0, err0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic one_scan1(input logic [15:0] pattern, input string name);
        int m;
        data1  = pattern;
        fault1 = 1'b0;
        ready1 = 1'b1;
        start_pulse1();
        wait_valid1(200, m);
        checks++;
        if (m !== exp_latency(1)) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, need %0d", name, m, exp_latency(1));
        end
        checks++;
        if (word1 !== pattern || err1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_word: got word=%h err=%b busy=%b, need word=%h err=0 busy=1",
                     name, word1, err1, busy1, pattern);
        end
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_width: got valid=%b busy=%b one cycle later, need 0 0",
                     name, valid1, busy1);
        end
    endtask

    task automatic test_basic();
        one_scan1(16'hA5C3, "basic");
        for (int i = 0; i < 3; i++) begin
            one_scan1(16'($urandom), "random");
        end
    endtask

    task automatic test_settle0();
        for (int r = 0; r < 3; r++) begin
            data0  = (r == 0) ? 16'hFFFF : 16'($urandom);
            fault0 = 1'b0;
            ready0 = 1'b1;
            start_pulse0();
            @(negedge clk);
            checks++;
            if (sel0 !== 4'd0 || en0 !== 1'b0 || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL s0_check_step: got sel=%0d en=%b busy=%b, need 0 0 1",
                         sel0, en0, busy0);
            end
            for (int k = 0; k < 16; k++) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (sel0 !== 4'(k) || en0 !== 1'b1 || valid0 !== 1'b0) begin
                    errors++;
                    $display("FAIL s0_sel_seq: got sel=%0d en=%b valid=%b, need sel=%0d en=1 valid=0",
                             sel0, en0, valid0, k);
                end
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid0 !== 1'b1 || word0 !== data0 || err0 !== 1'b0) begin
                errors++;
                $display("FAIL s0_word: got valid=%b word=%h err=%b at 17 cycles, need 1 %h 0",
                         valid0, word0, err0, data0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fault();
        int m;
        data1  = 16'h0000;
        fault1 = 1'b1;
        ready1 = 1'b1;
        start_pulse1();
        wait_valid1(200, m);
        checks++;
        if (m !== exp_latency(1) || word1 !== 16'h0000 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL fault: got cycles=%0d word=%h err=%b, need %0d 0000 1",
                     m, word1, err1, exp_latency(1));
        end
        fault1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_ready();
        int m;
        logic [15:0] pattern;
        pattern = 16'($urandom);
        data1   = pattern;
        ready1  = 1'b0;
        start_pulse1();
        wait_valid1(200, m);
        checks++;
        if (m !== exp_latency(1)) begin
            errors++;
            $display("FAIL hold_latency: got %0d, need %0d", m, exp_latency(1));
        end
        // Scramble the mux inputs so a stray restart would change the word.
        data1 = ~pattern;
        for (int i = 0; i < 10; i++) begin
            start1 = (i % 3 == 0);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid1 !== 1'b1 || busy1 !== 1'b1 || word1 !== pattern || en1 !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b busy=%b word=%h en=%b, need 1 1 %h 0",
                         valid1, busy1, word1, en1, pattern);
            end
        end
        start1 = 1'b0;
        ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0 || word1 !== pattern) begin
            errors++;
            $display("FAIL hold_release: got valid=%b busy=%b word=%h, need 0 0 %h",
                     valid1, busy1, word1, pattern);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got busy=%b after release, need 0", busy1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] pattern;
        data1  = 16'($urandom) | 16'h0001;
        ready1 = 1'b1;
        start_pulse1();
        n = 0;
        while (!(en1 && sel1 == 4'd7) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL midreset_reach_ch7: got no sel=7 in %0d cycles, need it", n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel1, en1, busy1, valid1, word1, err1} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got sel=%0d en=%b busy=%b valid=%b word=%h err=%b, need 0",
                     sel1, en1, busy1, valid1, word1, err1);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || en1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_waits: got busy=%b en=%b without start, need 0 0", busy1, en1);
        end
        pattern = ~data1;
        one_scan1(pattern, "after_reset");
    endtask

    task automatic test_back_to_back();
        int m;
        logic [15:0] a, b;
        a      = 16'($urandom);
        b      = ~a ^ 16'($urandom);
        data1  = a;
        ready1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1;
        wait_valid1(200, m);
        checks++;
        if (m !== exp_latency(1) || word1 !== a) begin
            errors++;
            $display("FAIL b2b_first: got cycles=%0d word=%h, need %0d %h",
                     m, word1, exp_latency(1), a);
        end
        data1 = b;
        wait_valid1(200, m);
        start1 = 1'b0;
        // One DONE cycle, one IDLE cycle, then a full scan.
        checks++;
        if (m !== exp_latency(1) + 2 || word1 !== b || err1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got cycles=%0d word=%h err=%b, need %0d %h 0",
                     m, word1, err1, exp_latency(1) + 2, b);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got busy=%b after start dropped, need 0", busy1);
        end
    endtask

    initial begin
        start1 = 1'b0; ready1 = 1'b1; fault1 = 1'b0; data1 = '0;
        start0 = 1'b0; ready0 = 1'b1; fault0 = 1'b0; data0 = '0;
        rst_n  = 1'b0;
        test_reset();
        test_basic();
        test_settle0();
        test_fault();
        test_hold_ready();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
